vga_stream_out: RTL



---
 rtl/vga_stream_out.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_stream_out.sv
// vga_stream_out: VGA timing generator that drains an RGB565 FIFO into a 10-bit DAC.
// Optional IDLE/ARM colour bars are enabled by defining VGA_TEST_PATTERN_EN.
module vga_stream_out #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_WD  = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               first_frame,
    input  logic               vga_fifo_empty,
    input  logic [DATA_WD-1:0] vga_fifo_i,
    output logic               rd_vga_fifo,
    output logic               vga_hs_o,
    output logic               vga_vs_o,
    output logic               vga_blank_n_o,
    output logic               vga_sync_n_o,
    output logic [9:0]         vga_r_o,
    output logic [9:0]         vga_g_o,
    output logic [9:0]         vga_b_o,
    output logic               frame_start_o,
    output logic               underflow_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_STREAM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    logic w_h_last;
    logic w_v_last;
    logic w_active;
    logic w_hs_n;
    logic w_vs_n;
    logic w_stream;
    logic w_uflow;
    logic w_origin;

    logic r_s1_active;
    logic r_s1_hs;
    logic r_s1_vs;
    logic r_s1_rd;
    logic r_s1_fs;
    logic r_underflow;

    logic [9:0] w_r;
    logic [9:0] w_g;
    logic [9:0] w_b;

    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);
    assign w_active = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs_n   = !((r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
    assign w_vs_n   = !((r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
    assign w_stream = (r_state == S_STREAM);
    assign w_origin = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    assign rd_vga_fifo  = w_stream && w_active && !vga_fifo_empty;
    assign w_uflow      = w_stream && w_active && vga_fifo_empty;
    assign vga_sync_n_o = 1'b0;
    assign underflow_o  = r_underflow;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? 10'd0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ARM waits for the last counter slot so the first read lands on (0,0)
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (first_frame) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (!first_frame) begin
                    w_state_nxt = S_IDLE;
                end else if (w_h_last && w_v_last) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!first_frame) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_underflow <= 1'b0;
        end else if (w_uflow) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] w_bar;
    logic [2:0] w_bar_rgb;
    logic       w_pat_on;
    logic [2:0] r_s1_pat;
    logic       r_s1_pat_on;

    always_comb begin
        w_bar = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (r_h_cnt >= 10'(i * BAR_W)) begin
                w_bar = 3'(i);
            end
        end
    end

    // bar order white,yellow,cyan,green,magenta,red,blue,black
    assign w_bar_rgb = {~w_bar[1], ~w_bar[2], ~w_bar[0]};
    assign w_pat_on  = !w_stream && w_active;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_pat    <= '0;
            r_s1_pat_on <= 1'b0;
        end else begin
            r_s1_pat    <= w_bar_rgb;
            r_s1_pat_on <= w_pat_on;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s1_rd     <= 1'b0;
            r_s1_fs     <= 1'b0;
        end else begin
            r_s1_active <= w_active;
            r_s1_hs     <= w_hs_n;
            r_s1_vs     <= w_vs_n;
            r_s1_rd     <= rd_vga_fifo;
            r_s1_fs     <= w_stream && w_origin;
        end
    end

    // FIFO data is valid the cycle after the read, i.e. alongside stage 1
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        if (r_s1_rd) begin
            w_r = {vga_fifo_i[15:11], vga_fifo_i[15:11]};
            w_g = {vga_fifo_i[10:5], vga_fifo_i[10:7]};
            w_b = {vga_fifo_i[4:0], vga_fifo_i[4:0]};
        end
`ifdef VGA_TEST_PATTERN_EN
        else if (r_s1_pat_on) begin
            w_r = {10{r_s1_pat[2]}};
            w_g = {10{r_s1_pat[1]}};
            w_b = {10{r_s1_pat[0]}};
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vga_hs_o      <= 1'b1;
            vga_vs_o      <= 1'b1;
            vga_blank_n_o <= 1'b0;
            frame_start_o <= 1'b0;
            vga_r_o       <= '0;
            vga_g_o       <= '0;
            vga_b_o       <= '0;
        end else begin
            vga_hs_o      <= r_s1_hs;
            vga_vs_o      <= r_s1_vs;
            vga_blank_n_o <= r_s1_active;
            frame_start_o <= r_s1_fs;
            vga_r_o       <= w_r;
            vga_g_o       <= w_g;
            vga_b_o       <= w_b;
        end
    end

endmodule
